instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the five-stage MIPS pipeline. It owns the program counter, drives the address of the combinational instruction memory, and registers the returned word into the IF/ID pipeline register. It arbitrates the next PC between sequential fetch, branch/jump redirects from later stages, the exception and interrupt vectors, and return-from-handler. It also holds the EPC register.

## Interface
- Parameters:
  - RESET_PC, 32'h0000_0000, user-mode start address.
  - IRQ_VECTOR, 32'h8000_0004, interrupt handler entry.
  - EXC_VECTOR, 32'h8000_0008, exception handler entry.
- Ports:
  - clk  in  1  single clock; all state updates on rising edge.
  - reset  in  1  synchronous, active-high.
  - imem_addr  out  32  equals current PC; combinational from the PC register.
  - imem_instr  in  32  instruction word for imem_addr, valid in the same cycle.
  - stall  in  1  load-use hazard; hold PC and IF/ID.
  - redirect  in  1  branch taken, j, jal or jr resolved downstream.
  - redirect_pc  in  32  target for redirect.
  - exc  in  1  exception reported by a downstream stage.
  - exc_pc  in  32  address of the faulting instruction.
  - irq  in  1  level-sensitive timer interrupt request.
  - eret  in  1  return-from-handler resolved downstream.
  - ifid_instr  out  32  registered instruction; 0 (nop) when invalid.
  - ifid_pc  out  32  registered fetch address.
  - ifid_pc_plus4  out  32  registered sequential address.
  - ifid_valid  out  1  IF/ID holds a real instruction.
  - epc  out  32  saved return address.
  - irq_taken  out  1  one-cycle pulse, registered, asserted the cycle after an interrupt is accepted.

## Operation
- Kernel mode is PC[31]=1. There is no separate mode bit.
- Sequential increment: pc_plus4 = {pc[31], pc[30:0] + 31'd4}.
  - Bit 31 is never changed by increment.
  - Overflow wraps inside the current half of the address space.
- Interrupt acceptance: irq_accept = irq & ~pc[31] & ~stall & ~redirect & ~exc & ~eret & ifid_valid.
  - Interrupts are never accepted in kernel mode.
  - They are never accepted in the cycle after a flush, so EPC cannot point into a squashed slot.
- Next-PC priority, highest first:
  1. reset → RESET_PC.
  2. exc → EXC_VECTOR; epc ← exc_pc.
  3. irq_accept → IRQ_VECTOR; epc ← pc. The current fetch is discarded and re-executed after return.
  4. eret → epc.
  5. redirect → redirect_pc.
  6. stall → pc (hold).
  7. Otherwise → pc_plus4.
- IF/ID update, same priority:
  - reset or a flush (exc, irq_accept, eret, redirect) → instr=0, pc=0, pc_plus4=0, valid=0.
  - stall alone → hold all fields.
  - Otherwise → capture imem_instr, pc, pc_plus4; valid=1.
- Redirect overrides stall. A resolved control transfer always wins over a load-use hold.
- Branch delay slots are handled by the software-placed nop. This block performs no delay-slot logic.
- EPC is written only on exc or irq_accept. On a simultaneous exc and irq, exc wins and irq remains pending.

## Timing
- Reset values: pc=RESET_PC; imem_addr=RESET_PC; ifid_* = 0; ifid_valid=0; epc=0; irq_taken=0.
- Fetch latency: one cycle from imem_addr to ifid_instr.
- Redirect, exc or eret asserted in cycle N:
  - PC holds the target at N+1.
  - IF/ID is invalid at N+1.
  - The first target instruction is in IF/ID at N+2.
- irq_accept in cycle N: pc=IRQ_VECTOR, epc=old pc and irq_taken=1 at N+1.
- Reset asserted mid-stream dominates every other input on that edge.

## Configuration
- FETCH_IRQ_EN defined:
  - The interrupt path is compiled in as described.
- FETCH_IRQ_EN undefined:
  - irq is ignored; irq_accept is constant 0.
  - irq_taken is tied 0.
  - EPC is written only by exc.
  - The port list is unchanged.

## Test plan
- Reset then free-run with no hazards:
  - imem_addr = 0, 4, 8, 12 on successive cycles.
  - ifid_pc lags by one cycle; ifid_valid rises one cycle after reset deasserts.
- stall held 2 cycles at pc=0x10:
  - imem_addr stays 0x10 for 3 cycles.
  - IF/ID is frozen on the instruction from 0x0C.
  - Sequential fetch then resumes at 0x14.
- redirect with redirect_pc=0x8C while stall=1 at pc=0xD8:
  - Next pc=0x8C; IF/ID is nop with valid=0 for one cycle.
  - ifid_pc=0x8C on the following cycle.
- irq=1 at pc=0x100 with ifid_valid=1 and no other events:
  - pc=0x80000004, epc=0x100, irq_taken pulses for one cycle.
  - irq held high while pc=0x80000004 causes no re-entry.
- exc with exc_pc=0x80000010 together with irq:
  - pc=0x80000008, epc=0x80000010.
  - Next, eret → pc=0x80000010 and IF/ID is flushed.
- pc=0x7FFFFFFC, sequential: next pc=0x00000000 (wraps, bit 31 unchanged).
- pc=0xFFFFFFFC, sequential: next pc=0x80000000.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, addresses instruction memory, fills the IF/ID register and holds EPC.
// Build option FETCH_IRQ_EN compiles in the timer-interrupt entry path.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc,
  input  logic [31:0] exc_pc,
  input  logic        irq,
  input  logic        eret,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] epc,
  output logic        irq_taken
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        irq_accept;
  logic        flush;

  // Increment never touches bit 31, so sequential fetch cannot cross the user/kernel boundary.
  assign pc_plus4  = {pc[31], pc[30:0] + 31'd4};
  assign imem_addr = pc;

`ifdef FETCH_IRQ_EN
  // Only taken in user mode on a quiet cycle holding a real instruction, so EPC is never a squashed slot.
  assign irq_accept = irq & ~pc[31] & ~stall & ~redirect & ~exc & ~eret & ifid_valid;
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_accept = 1'b0;
`endif

  assign flush = exc | irq_accept | eret | redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      ifid_instr    <= 32'd0;
      ifid_pc       <= 32'd0;
      ifid_pc_plus4 <= 32'd0;
      ifid_valid    <= 1'b0;
      epc           <= 32'd0;
      irq_taken     <= 1'b0;
    end else begin
      if (exc)             pc <= EXC_VECTOR;
      else if (irq_accept) pc <= IRQ_VECTOR;
      else if (eret)       pc <= epc;
      else if (redirect)   pc <= redirect_pc;
      else if (!stall)     pc <= pc_plus4;

      if (flush) begin
        ifid_instr    <= 32'd0;
        ifid_pc       <= 32'd0;
        ifid_pc_plus4 <= 32'd0;
        ifid_valid    <= 1'b0;
      end else if (!stall) begin
        ifid_instr    <= imem_instr;
        ifid_pc       <= pc;
        ifid_pc_plus4 <= pc_plus4;
        ifid_valid    <= 1'b1;
      end

      if (exc)             epc <= exc_pc;
      else if (irq_accept) epc <= pc;

      irq_taken <= irq_accept;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed plus randomized bench for instruction_fetch against a cycle-level reference model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
`ifdef FETCH_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        exc = 1'b0;
  logic [31:0] exc_pc = 32'd0;
  logic        irq = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4, epc;
  logic        ifid_valid, irq_taken;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_epc;
  logic        m_valid, m_taken;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  instruction_fetch #(
    .RESET_PC(RESET_PC), .IRQ_VECTOR(IRQ_VECTOR), .EXC_VECTOR(EXC_VECTOR)
  ) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .exc(exc), .exc_pc(exc_pc), .irq(irq), .eret(eret),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .epc(epc), .irq_taken(irq_taken)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sequential address: stays in the same half of the address space, wrapping inside it.
  function automatic logic [31:0] seq_next(input logic [31:0] a);
    logic [31:0] half_base;
    logic [31:0] offset;
    half_base = (a >= 32'h8000_0000) ? 32'h8000_0000 : 32'h0;
    offset    = (a - half_base + 32'd4) % 32'h8000_0000;
    return half_base + offset;
  endfunction

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc", ifid_pc, m_ifpc);
    chk("ifid_pc_plus4", ifid_pc_plus4, m_ifpc4);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("epc", epc, m_epc);
    chk("irq_taken", {31'd0, irq_taken}, {31'd0, m_taken});
  endtask

  // One clock: drive inputs, check the current registered state, then advance the model.
  task automatic step(input bit do_check, input logic rst, input logic stl, input logic rdr,
                      input logic [31:0] rpc, input logic ex, input logic [31:0] xpc,
                      input logic iq, input logic er);
    bit in_user, accept, flush;
    logic [31:0] nxt_pc;
    @(negedge clk);
    reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc;
    exc = ex; exc_pc = xpc; irq = iq; eret = er;
    #1;
    if (do_check) check_all();
    in_user = (m_pc < 32'h8000_0000);
    accept  = IRQ_EN && iq && in_user && m_valid && !stl && !rdr && !ex && !er;
    flush   = ex || accept || er || rdr;
    if (rst) begin
      m_pc = RESET_PC; m_instr = 0; m_ifpc = 0; m_ifpc4 = 0; m_valid = 0; m_epc = 0; m_taken = 0;
    end else begin
      if (ex)          nxt_pc = EXC_VECTOR;
      else if (accept) nxt_pc = IRQ_VECTOR;
      else if (er)     nxt_pc = m_epc;
      else if (rdr)    nxt_pc = rpc;
      else if (stl)    nxt_pc = m_pc;
      else             nxt_pc = seq_next(m_pc);
      if (flush) begin
        m_instr = 0; m_ifpc = 0; m_ifpc4 = 0; m_valid = 0;
      end else if (!stl) begin
        m_instr = mem_word(m_pc); m_ifpc = m_pc; m_ifpc4 = seq_next(m_pc); m_valid = 1;
      end
      if (ex)          m_epc = xpc;
      else if (accept) m_epc = m_pc;
      m_taken = accept;
      m_pc = nxt_pc;
    end
    @(posedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset; state is unknown until the first edge so only check afterwards.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    // Free-run from 0: pc reaches 0x10 after four cycles.
    run(4);
    // Stall two cycles at 0x10, then resume.
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    run(2);
    // Reach 0xD8, then redirect to 0x8C while stalled.
    step(1, 0, 0, 1, 32'h0000_00D8, 0, 0, 0, 0);
    step(1, 0, 1, 1, 32'h0000_008C, 0, 0, 0, 0);
    run(2);
    // Arrive at 0x100 with a valid IF/ID, then hold irq high.
    step(1, 0, 0, 1, 32'h0000_00F8, 0, 0, 0, 0);
    run(2);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    // Back to user code, then exc together with irq, then eret.
    step(1, 0, 0, 1, 32'h0000_0200, 0, 0, 0, 0);
    run(2);
    step(1, 0, 0, 0, 0, 1, 32'h8000_0010, 1, 0);
    run(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    run(2);
    // Wrap checks in both halves.
    step(1, 0, 0, 1, 32'h7FFF_FFF8, 0, 0, 0, 0);
    run(3);
    step(1, 0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0);
    run(3);
    // Mid-stream reset with every other input active.
    step(1, 1, 1, 1, 32'h0000_0444, 1, 32'h0000_0888, 1, 1);
    run(3);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc, xpc;
      rpc = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 29'($urandom()), 2'b00};
      xpc = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 29'($urandom()), 2'b00};
      step(1, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 12, rpc,
           $urandom_range(0, 99) < 4, xpc,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 6);
    end
    @(negedge clk);
    #1;
    check_all();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
